// File: rtl/id_ex_if.sv
// Decode-to-execute boundary bundle: decoded fields in, registered EX fields and
// hazard/stall status out.
interface id_ex_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  id_valid;
  logic [31:0]           id_instr;
  logic [DATA_WIDTH-1:0] id_pc;
  logic [4:0]            id_rs1_addr;
  logic [4:0]            id_rs2_addr;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [4:0]            id_rd_addr;
  logic [DATA_WIDTH-1:0] id_rs1_data;
  logic [DATA_WIDTH-1:0] id_rs2_data;
  logic [DATA_WIDTH-1:0] id_imm;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_mem_write;
  logic [3:0]            id_alu_op;
  logic                  ext_stall;
  logic                  flush;

  logic                  ex_valid;
  logic [31:0]           ex_instr;
  logic [DATA_WIDTH-1:0] ex_pc;
  logic [4:0]            ex_rs1_addr;
  logic [4:0]            ex_rs2_addr;
  logic [4:0]            ex_rd_addr;
  logic [DATA_WIDTH-1:0] ex_rs1_data;
  logic [DATA_WIDTH-1:0] ex_rs2_data;
  logic [DATA_WIDTH-1:0] ex_imm;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic [3:0]            ex_alu_op;
  logic                  stall_if_id;
  logic                  load_use_hazard;
  logic [CNT_WIDTH-1:0]  bubble_count;

  modport master (
    output id_valid, id_instr, id_pc, id_rs1_addr, id_rs2_addr, id_uses_rs1,
           id_uses_rs2, id_rd_addr, id_rs1_data, id_rs2_data, id_imm,
           id_reg_write, id_mem_read, id_mem_write, id_alu_op, ext_stall, flush,
    input  ex_valid, ex_instr, ex_pc, ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
           ex_rs1_data, ex_rs2_data, ex_imm, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_alu_op, stall_if_id, load_use_hazard, bubble_count
  );

  modport slave (
    input  id_valid, id_instr, id_pc, id_rs1_addr, id_rs2_addr, id_uses_rs1,
           id_uses_rs2, id_rd_addr, id_rs1_data, id_rs2_data, id_imm,
           id_reg_write, id_mem_read, id_mem_write, id_alu_op, ext_stall, flush,
    output ex_valid, ex_instr, ex_pc, ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
           ex_rs1_data, ex_rs2_data, ex_imm, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_alu_op, stall_if_id, load_use_hazard, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and
// a saturating count of inserted bubbles.
module id_ex_stage #(
  parameter int          DATA_WIDTH = 32,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic  clk,
  input  logic  rst_n,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic                  valid;
    logic [31:0]           instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [4:0]            rs1_addr;
    logic [4:0]            rs2_addr;
    logic [4:0]            rd_addr;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] imm;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [3:0]            alu_op;
  } ex_fields_t;

  // Zeroed addresses keep the forwarding unit from matching on a bubble.
  function automatic ex_fields_t bubble_fields();
    ex_fields_t f;
    f       = '0;
    f.instr = NOP_INSTR;
    return f;
  endfunction

  ex_fields_t           ex_r;
  ex_fields_t           id_fields_s;
  logic [CNT_WIDTH-1:0] bubble_count_r;
  logic                 rs1_match_s;
  logic                 rs2_match_s;
  logic                 hazard_s;
  logic                 stall_s;

  // Decode fields as they would be captured; side effects killed when not valid.
  always_comb begin
    id_fields_s          = '0;
    id_fields_s.valid    = bus.id_valid;
    id_fields_s.instr    = bus.id_instr;
    id_fields_s.pc       = bus.id_pc;
    id_fields_s.rs1_addr = bus.id_rs1_addr;
    id_fields_s.rs2_addr = bus.id_rs2_addr;
    id_fields_s.rs1_data = bus.id_rs1_data;
    id_fields_s.rs2_data = bus.id_rs2_data;
    id_fields_s.imm      = bus.id_imm;
    id_fields_s.alu_op   = bus.id_alu_op;
    if (bus.id_valid) begin
      id_fields_s.rd_addr   = bus.id_rd_addr;
      id_fields_s.reg_write = bus.id_reg_write;
      id_fields_s.mem_read  = bus.id_mem_read;
      id_fields_s.mem_write = bus.id_mem_write;
    end else begin
      id_fields_s.rd_addr   = 5'd0;
      id_fields_s.reg_write = 1'b0;
      id_fields_s.mem_read  = 1'b0;
      id_fields_s.mem_write = 1'b0;
    end
  end

  // Load in EX whose result a source operand in decode needs this cycle.
  // The hold request ignores the hazard while reset is asserted.
  always_comb begin
    rs1_match_s = bus.id_uses_rs1 & (bus.id_rs1_addr == ex_r.rd_addr);
    rs2_match_s = bus.id_uses_rs2 & (bus.id_rs2_addr == ex_r.rd_addr);
    hazard_s    = ex_r.valid & ex_r.mem_read & (ex_r.rd_addr != 5'd0) &
                  bus.id_valid & (rs1_match_s | rs2_match_s);
    stall_s     = bus.ext_stall | (hazard_s & ~bus.flush & rst_n);
  end

  // Pipeline register and bubble counter: reset > flush > hold > bubble > load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_r           <= bubble_fields();
      bubble_count_r <= '0;
    end else if (bus.flush) begin
      ex_r           <= bubble_fields();
      bubble_count_r <= bubble_count_r;
    end else if (bus.ext_stall) begin
      ex_r           <= ex_r;
      bubble_count_r <= bubble_count_r;
    end else if (hazard_s) begin
      ex_r <= bubble_fields();
      if (bubble_count_r != {CNT_WIDTH{1'b1}}) begin
        bubble_count_r <= bubble_count_r + CNT_WIDTH'(1);
      end else begin
        bubble_count_r <= bubble_count_r;
      end
    end else begin
      ex_r           <= id_fields_s;
      bubble_count_r <= bubble_count_r;
    end
  end

  assign bus.ex_valid        = ex_r.valid;
  assign bus.ex_instr        = ex_r.instr;
  assign bus.ex_pc           = ex_r.pc;
  assign bus.ex_rs1_addr     = ex_r.rs1_addr;
  assign bus.ex_rs2_addr     = ex_r.rs2_addr;
  assign bus.ex_rd_addr      = ex_r.rd_addr;
  assign bus.ex_rs1_data     = ex_r.rs1_data;
  assign bus.ex_rs2_data     = ex_r.rs2_data;
  assign bus.ex_imm          = ex_r.imm;
  assign bus.ex_reg_write    = ex_r.reg_write;
  assign bus.ex_mem_read     = ex_r.mem_read;
  assign bus.ex_mem_write    = ex_r.mem_write;
  assign bus.ex_alu_op       = ex_r.alu_op;
  assign bus.stall_if_id     = stall_s;
  assign bus.load_use_hazard = hazard_s;
  assign bus.bubble_count    = bubble_count_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage with a 2-bit bubble counter.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int CW = 2;

  typedef struct packed {
    logic        rst_n;
    logic        v;
    logic [31:0] instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rw;
    logic        mr;
    logic        es;
    logic        fl;
  } in_t;

  typedef struct packed {
    logic        ev;
    logic [31:0] instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mr;
    logic        rw;
  } ex_t;

  typedef struct packed {
    in_t         i;
    logic        haz;
    logic        stall;
    ex_t         e;
    logic [1:0]  cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];

  in_t add3, lw5, use5, lw0, usex0, addi, lw9, inv, use5b;
  ex_t ADD3, LW5, USE5, LW0, USE0, ADDI, LW9, INV, USE5B, BUB;

  id_ex_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  id_ex_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .NOP_INSTR(32'h00000013)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic in_t mkin(input logic v, input logic [31:0] instr,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic [31:0] data, input logic rw, input logic mr);
    in_t r;
    r.rst_n = 1'b1; r.v = v; r.instr = instr; r.rs1 = rs1; r.rs2 = rs2;
    r.u1 = u1; r.u2 = u2; r.rd = rd; r.data = data; r.rw = rw; r.mr = mr;
    r.es = 1'b0; r.fl = 1'b0;
    return r;
  endfunction

  function automatic ex_t mkex(input logic ev, input logic [31:0] instr,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] data,
                               input logic mr, input logic rw);
    ex_t r;
    r.ev = ev; r.instr = instr; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
    r.data = data; r.mr = mr; r.rw = rw;
    return r;
  endfunction

  function automatic in_t mod(input in_t x, input logic rst_n_v, input logic es, input logic fl);
    in_t r;
    r = x; r.rst_n = rst_n_v; r.es = es; r.fl = fl;
    return r;
  endfunction

  task automatic row(input in_t i, input logic haz, input logic stall, input ex_t e,
                     input logic [1:0] cnt);
    vec_t r;
    r.i = i; r.haz = haz; r.stall = stall; r.e = e; r.cnt = cnt;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t x, input logic [31:0] pc);
    rst_n            = x.rst_n;
    bus.id_valid     = x.v;
    bus.id_instr     = x.instr;
    bus.id_pc        = pc;
    bus.id_rs1_addr  = x.rs1;
    bus.id_rs2_addr  = x.rs2;
    bus.id_uses_rs1  = x.u1;
    bus.id_uses_rs2  = x.u2;
    bus.id_rd_addr   = x.rd;
    bus.id_rs1_data  = x.data;
    bus.id_rs2_data  = x.data ^ 32'h0000ffff;
    bus.id_imm       = 32'h00000000;
    bus.id_reg_write = x.rw;
    bus.id_mem_read  = x.mr;
    bus.id_mem_write = 1'b0;
    bus.id_alu_op    = 4'h0;
    bus.ext_stall    = x.es;
    bus.flush        = x.fl;
  endtask

  task automatic chk_ex(input string tag, input ex_t e);
    chk({tag, ".ex_valid"},     {31'd0, bus.ex_valid},     {31'd0, e.ev});
    chk({tag, ".ex_instr"},     bus.ex_instr,              e.instr);
    chk({tag, ".ex_rs1_addr"},  {27'd0, bus.ex_rs1_addr},  {27'd0, e.rs1});
    chk({tag, ".ex_rs2_addr"},  {27'd0, bus.ex_rs2_addr},  {27'd0, e.rs2});
    chk({tag, ".ex_rd_addr"},   {27'd0, bus.ex_rd_addr},   {27'd0, e.rd});
    chk({tag, ".ex_rs1_data"},  bus.ex_rs1_data,           e.data);
    chk({tag, ".ex_mem_read"},  {31'd0, bus.ex_mem_read},  {31'd0, e.mr});
    chk({tag, ".ex_reg_write"}, {31'd0, bus.ex_reg_write}, {31'd0, e.rw});
  endtask

  initial begin
    add3  = mkin(1'b1, 32'h002081b3, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3,  32'h5,  1'b1, 1'b0);
    lw5   = mkin(1'b1, 32'h0000a283, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5,  32'h11, 1'b1, 1'b1);
    use5  = mkin(1'b1, 32'h00128333, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6,  32'h22, 1'b1, 1'b0);
    lw0   = mkin(1'b1, 32'h0000a003, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0,  32'h33, 1'b1, 1'b1);
    usex0 = mkin(1'b1, 32'h000003b3, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7,  32'h44, 1'b1, 1'b0);
    addi  = mkin(1'b1, 32'h00510413, 5'd2, 5'd5, 1'b1, 1'b0, 5'd8,  32'h66, 1'b1, 1'b0);
    lw9   = mkin(1'b1, 32'h00012483, 5'd2, 5'd0, 1'b1, 1'b0, 5'd9,  32'h77, 1'b1, 1'b1);
    inv   = mkin(1'b0, 32'h00048533, 5'd9, 5'd0, 1'b1, 1'b1, 5'd10, 32'h88, 1'b1, 1'b1);
    use5b = mkin(1'b1, 32'h00508333, 5'd1, 5'd5, 1'b1, 1'b1, 5'd6,  32'h22, 1'b1, 1'b0);

    ADD3  = mkex(1'b1, 32'h002081b3, 5'd1, 5'd2, 5'd3, 32'h5,  1'b0, 1'b1);
    LW5   = mkex(1'b1, 32'h0000a283, 5'd1, 5'd0, 5'd5, 32'h11, 1'b1, 1'b1);
    USE5  = mkex(1'b1, 32'h00128333, 5'd5, 5'd1, 5'd6, 32'h22, 1'b0, 1'b1);
    LW0   = mkex(1'b1, 32'h0000a003, 5'd1, 5'd0, 5'd0, 32'h33, 1'b1, 1'b1);
    USE0  = mkex(1'b1, 32'h000003b3, 5'd0, 5'd0, 5'd7, 32'h44, 1'b0, 1'b1);
    ADDI  = mkex(1'b1, 32'h00510413, 5'd2, 5'd5, 5'd8, 32'h66, 1'b0, 1'b1);
    LW9   = mkex(1'b1, 32'h00012483, 5'd2, 5'd0, 5'd9, 32'h77, 1'b1, 1'b1);
    INV   = mkex(1'b0, 32'h00048533, 5'd9, 5'd0, 5'd0, 32'h88, 1'b0, 1'b0);
    USE5B = mkex(1'b1, 32'h00508333, 5'd1, 5'd5, 5'd6, 32'h22, 1'b0, 1'b1);
    BUB   = mkex(1'b0, 32'h00000013, 5'd0, 5'd0, 5'd0, 32'h0,  1'b0, 1'b0);

    row(add3,                     1'b0, 1'b0, ADD3,  2'd0);
    row(lw5,                      1'b0, 1'b0, LW5,   2'd0);
    row(use5,                     1'b1, 1'b1, BUB,   2'd1);
    row(use5,                     1'b0, 1'b0, USE5,  2'd1);
    row(lw0,                      1'b0, 1'b0, LW0,   2'd1);
    row(usex0,                    1'b0, 1'b0, USE0,  2'd1);
    row(lw5,                      1'b0, 1'b0, LW5,   2'd1);
    row(addi,                     1'b0, 1'b0, ADDI,  2'd1);
    row(lw9,                      1'b0, 1'b0, LW9,   2'd1);
    row(inv,                      1'b0, 1'b0, INV,   2'd1);
    row(lw5,                      1'b0, 1'b0, LW5,   2'd1);
    row(mod(use5, 1'b1, 1'b1, 1'b0), 1'b1, 1'b1, LW5, 2'd1);
    row(mod(use5, 1'b1, 1'b1, 1'b0), 1'b1, 1'b1, LW5, 2'd1);
    row(use5,                     1'b1, 1'b1, BUB,   2'd2);
    row(use5,                     1'b0, 1'b0, USE5,  2'd2);
    row(lw5,                      1'b0, 1'b0, LW5,   2'd2);
    row(mod(use5, 1'b1, 1'b1, 1'b1), 1'b1, 1'b1, BUB, 2'd2);
    row(lw5,                      1'b0, 1'b0, LW5,   2'd2);
    row(mod(use5, 1'b1, 1'b0, 1'b1), 1'b1, 1'b0, BUB, 2'd2);
    row(lw5,                      1'b0, 1'b0, LW5,   2'd2);
    row(use5b,                    1'b1, 1'b1, BUB,   2'd3);
    row(use5b,                    1'b0, 1'b0, USE5B, 2'd3);
    row(lw5,                      1'b0, 1'b0, LW5,   2'd3);
    row(use5,                     1'b1, 1'b1, BUB,   2'd3);
    row(lw5,                      1'b0, 1'b0, LW5,   2'd3);
    row(use5,                     1'b1, 1'b1, BUB,   2'd3);
    row(lw5,                      1'b0, 1'b0, LW5,   2'd3);
    row(mod(use5, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1, BUB, 2'd0);
    row(use5,                     1'b0, 1'b0, USE5,  2'd0);

    // Reset state, with full field coverage.
    drive(mod(add3, 1'b0, 1'b0, 1'b0), 32'h00000100);
    repeat (2) @(posedge clk);
    #1;
    chk_ex("reset", BUB);
    chk("reset.ex_pc",        bus.ex_pc, 32'h0);
    chk("reset.ex_rs2_data",  bus.ex_rs2_data, 32'h0);
    chk("reset.ex_imm",       bus.ex_imm, 32'h0);
    chk("reset.ex_alu_op",    {28'd0, bus.ex_alu_op}, 32'h0);
    chk("reset.ex_mem_write", {31'd0, bus.ex_mem_write}, 32'h0);
    chk("reset.bubble_count", {30'd0, bus.bubble_count}, 32'h0);
    chk("reset.stall_if_id",  {31'd0, bus.stall_if_id}, 32'h0);

    // Pass-through of every field.
    @(negedge clk);
    drive(add3, 32'h00000200);
    bus.id_rs2_data  = 32'h7;
    bus.id_imm       = 32'hfffff800;
    bus.id_alu_op    = 4'ha;
    bus.id_mem_write = 1'b1;
    #1;
    chk("pass.stall_if_id", {31'd0, bus.stall_if_id}, 32'h0);
    @(posedge clk);
    #1;
    chk_ex("pass", ADD3);
    chk("pass.ex_pc",        bus.ex_pc, 32'h00000200);
    chk("pass.ex_rs2_data",  bus.ex_rs2_data, 32'h7);
    chk("pass.ex_imm",       bus.ex_imm, 32'hfffff800);
    chk("pass.ex_alu_op",    {28'd0, bus.ex_alu_op}, 32'ha);
    chk("pass.ex_mem_write", {31'd0, bus.ex_mem_write}, 32'h1);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k].i, 32'h00001000 + 32'(k * 4));
      #1;
      chk($sformatf("v%0d.load_use_hazard", k), {31'd0, bus.load_use_hazard}, {31'd0, vecs[k].haz});
      chk($sformatf("v%0d.stall_if_id", k), {31'd0, bus.stall_if_id}, {31'd0, vecs[k].stall});
      @(posedge clk);
      #1;
      chk_ex($sformatf("v%0d", k), vecs[k].e);
      chk($sformatf("v%0d.bubble_count", k), {30'd0, bus.bubble_count}, {30'd0, vecs[k].cnt});
    end

    // Three cycles of ext_stall with changing decode values: EX state frozen.
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      drive(mod((s == 0) ? lw5 : (s == 1) ? addi : lw9, 1'b1, 1'b1, 1'b0), 32'h00003000 + 32'(s));
      #1;
      chk($sformatf("hold%0d.stall_if_id", s), {31'd0, bus.stall_if_id}, 32'h1);
      @(posedge clk);
      #1;
      chk_ex($sformatf("hold%0d", s), USE5);
      chk($sformatf("hold%0d.ex_pc", s), bus.ex_pc, 32'h00001070);
      chk($sformatf("hold%0d.ex_rs2_data", s), bus.ex_rs2_data, 32'h0000ffdd);
    end
    @(negedge clk);
    drive(addi, 32'h00004000);
    #1;
    chk("release.stall_if_id", {31'd0, bus.stall_if_id}, 32'h0);
    @(posedge clk);
    #1;
    chk_ex("release", ADDI);
    chk("release.ex_pc", bus.ex_pc, 32'h00004000);
    chk("release.bubble_count", {30'd0, bus.bubble_count}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection and bubble insertion.
- Captures decoded operands and control from the decode stage.
- Drives EX-stage fields, including ex_rs1_addr, ex_rs2_addr and ex_instr, which the forwarding unit consumes.
- Issues the IF/ID hold request when a load result cannot be forwarded in time.

Parameters:
- DATA_WIDTH, 32, width of operand, immediate and PC fields.
- CNT_WIDTH, 16, width of the saturating bubble counter.
- NOP_INSTR, 32'h00000013, instruction word loaded on bubble, flush and reset (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- id_valid  input  1  decode stage holds a valid instruction.
- id_instr  input  32  decoded instruction word.
- id_pc  input  DATA_WIDTH  instruction PC.
- id_rs1_addr / id_rs2_addr  input  5 each  source register addresses.
- id_uses_rs1 / id_uses_rs2  input  1 each  the instruction actually reads rs1 / rs2.
- id_rd_addr  input  5  destination register.
- id_rs1_data / id_rs2_data  input  DATA_WIDTH each  register-file read data.
- id_imm  input  DATA_WIDTH  immediate.
- id_reg_write, id_mem_read, id_mem_write  input  1 each  control bits.
- id_alu_op  input  4  ALU operation code.
- ext_stall  input  1  downstream/memory stall; freezes this stage.
- flush  input  1  branch/jump redirect from EX; kills the instruction in decode.
- ex_valid  output  1  registered valid.
- ex_instr, ex_pc, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_rs1_data, ex_rs2_data, ex_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_op  output  same widths as the id_ counterparts  registered EX-stage fields.
- stall_if_id  output  1  hold PC and IF/ID this cycle.
- load_use_hazard  output  1  combinational hazard flag, for debug and perf.
- bubble_count  output  CNT_WIDTH  saturating count of load-use bubbles inserted.

Behaviour:
- Reset (rst_n=0 at an edge), which overrides all other inputs:
  - Bubble contents loaded: ex_valid=0, ex_instr=NOP_INSTR.
  - All address, data and control outputs 0.
  - bubble_count=0.
- Hazard, combinational: load_use_hazard = ex_valid & ex_mem_read & (ex_rd_addr!=0) & id_valid & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)).
- stall_if_id = ext_stall | (load_use_hazard & ~flush). It is combinational, so during reset it equals ext_stall.
- Register update per edge, rst_n=1, priority order:
  1. flush=1: load bubble. Flush wins over ext_stall and hazard.
  2. ext_stall=1: hold all ex_ registers unchanged. bubble_count does not change.
  3. load_use_hazard=1: load bubble; bubble_count increments, saturating at all-ones.
  4. Otherwise: load all id_ fields, with ex_valid=id_valid.
- When id_valid=0 on a normal load: ex_reg_write, ex_mem_read, ex_mem_write and ex_rd_addr are forced to 0; other fields are captured as-is.
- Bubble contents:
  - ex_valid=0, ex_instr=NOP_INSTR.
  - ex_rs1_addr, ex_rs2_addr, ex_rd_addr = 0, so no spurious forwarding.
  - All control bits 0; data, imm and pc 0.
- Latency: 1 cycle from id_ inputs to ex_ outputs.
- A load-use stall lasts exactly one cycle. After the bubble, ex_mem_read=0, so the hazard clears and the held instruction loads on the next edge. The forwarding unit then supplies the load data from MEM.
- A hazard and ext_stall in the same cycle: hold wins, and no bubble is counted. The hazard re-evaluates once the stall drops.
- A reset asserted mid-stall clears everything in one edge. No residual stall beyond ext_stall.

Test Plan:
- Pass-through: id_valid=1, add x3,x1,x2 (32'h002081b3), id_rs1_data=5, id_rs2_data=7, id_reg_write=1 -> next cycle ex_instr=32'h002081b3, ex_rs1_addr=1, ex_rs2_addr=2, ex_rd_addr=3, ex_valid=1, stall_if_id=0.
- Load-use: lw x5 in EX (ex_mem_read=1, ex_rd_addr=5), decode holds add x6,x5,x1 with id_uses_rs1=1 -> load_use_hazard=1, stall_if_id=1; next cycle ex_valid=0, ex_instr=32'h00000013, bubble_count=1; following cycle the add is loaded and stall_if_id=0.
- No false stall:
  - lw x0 followed by a use of x0 -> hazard=0.
  - lw x5 followed by an instruction with id_rs2_addr=5 but id_uses_rs2=0 -> hazard=0.
- ext_stall held 3 cycles with new id_ values -> ex_ outputs unchanged and stall_if_id=1 throughout; the loaded value updates on the first edge after ext_stall=0.
- Flush with hazard and ext_stall all asserted in the same cycle -> next cycle bubble loaded, stall_if_id=0 during the flush cycle (ext_stall=0 case), bubble_count unchanged.
- CNT_WIDTH=2 with 5 consecutive load-use pairs -> bubble_count reads 1,2,3,3,3. Then assert rst_n=0 for one edge while a hazard is present -> bubble_count=0, ex_valid=0, all ex_ addresses 0.
